// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared encodings for the multiply/divide unit, also imported by the
//   decode stage.
//   op encodings : MD_MULTU / MD_DIVU / MD_MULT / MD_DIV (op[0] = divide,
//                  op[1] = signed)
//   state type   : md_state_t with MD_IDLE / MD_RUN / MD_FIX
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_neg.sv
// muldiv_neg
//   Conditional two's-complement negate.
//   Ports:
//     neg  in   1      negate when 1, pass through when 0
//     in   in   WIDTH  value
//     out  out  WIDTH  neg ? -in : in
module muldiv_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? ('0 - in) : in;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit for the EX stage; owns HI/LO.
//   MULT/MULTU/DIV/DIVU take WIDTH iteration cycles plus one FIX cycle;
//   MTHI/MTLO write HI/LO directly while idle.
//   Configuration macro: MULDIV_SIGNED_EN enables signed MULT/DIV; when
//   undefined, op[1] is ignored and no sign logic is built.
//   Ports:
//     clock        in   1      clock, posedge
//     reset        in   1      synchronous, active-high
//     start        in   1      begin operation (sampled only in IDLE)
//     op           in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//     src_a        in   WIDTH  multiplicand / dividend
//     src_b        in   WIDTH  multiplier / divisor
//     hi_we        in   1      MTHI strobe
//     lo_we        in   1      MTLO strobe
//     wdata        in   WIDTH  MTHI/MTLO data
//     busy         out  1      operation in progress
//     done         out  1      one-cycle pulse, hi/lo hold the result
//     hi           out  WIDTH  HI (product upper half / remainder)
//     lo           out  WIDTH  LO (product lower half / quotient)
//     div_by_zero  out  1      last divide had src_b == 0
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {rem, dividend}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               dz_pend;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q, neg_r;

  assign a_neg = op[1] & src_a[WIDTH-1];
  assign b_neg = op[1] & src_b[WIDTH-1];

  muldiv_neg #(.WIDTH(WIDTH)) u_mag_a (.neg(a_neg), .in(src_a), .out(a_mag));
  muldiv_neg #(.WIDTH(WIDTH)) u_mag_b (.neg(b_neg), .in(src_b), .out(b_mag));

  // Product and quotient share the sign(a)^sign(b) flag; remainder follows a.
  muldiv_neg #(.WIDTH(2*WIDTH)) u_fix_p (.neg(neg_q), .in(acc), .out(prod_fix));
  muldiv_neg #(.WIDTH(WIDTH)) u_fix_q (.neg(neg_q), .in(acc[WIDTH-1:0]), .out(quot_fix));
  muldiv_neg #(.WIDTH(WIDTH)) u_fix_r (.neg(neg_r), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_fix));
`else
  logic unused_op_sign;

  assign unused_op_sign = op[1];
  assign a_mag    = src_a;
  assign b_mag    = src_b;
  assign prod_fix = acc;
  assign quot_fix = acc[WIDTH-1:0];
  assign rem_fix  = acc[2*WIDTH-1:WIDTH];
`endif

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial, div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign accept = (state == MD_IDLE) && start;
  assign busy   = (state != MD_IDLE);

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: bring the next dividend bit into the remainder and keep
  // the subtraction only if it did not borrow. rem < divisor holds between
  // steps, so bit WIDTH of the difference is a clean borrow flag.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opnd};
  assign div_rem   = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_next  = {div_rem, acc[WIDTH-2:0], ~div_diff[WIDTH]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      dz_pend     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (accept) begin
            state       <= MD_RUN;
            cnt         <= CW'(WIDTH - 1);
            is_div      <= md_is_div(op);
            opnd        <= md_is_div(op) ? b_mag : a_mag;
            acc         <= {{WIDTH{1'b0}}, (md_is_div(op) ? a_mag : b_mag)};
            dz_pend     <= md_is_div(op) && (src_b == '0);
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MD_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= MD_FIX;
        end
        MD_FIX: begin
          hi          <= is_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
          lo          <= is_div ? quot_fix : prod_fix[WIDTH-1:0];
          div_by_zero <= dz_pend;
          done        <= 1'b1;
          state       <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference model: plain SV arithmetic on the architectural rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic        sgn;
    logic [63:0] p;
    int          ia, ib;
    longint      la, lb;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    edz = 1'b0;
    ia = a; ib = b; la = ia; lb = ib;
    if (!o[0]) begin
      if (sgn) p = la * lb;
      else     p = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      edz = 1'b1;
      eh  = a;
      el  = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = a; eh = 0;
      end else begin
        el = ia / ib; eh = ia % ib;
      end
    end else begin
      el = a / b; eh = a % b;
    end
  endfunction

  // Issues one operation and follows it to done (bounded). Operands are
  // scrambled after the accept edge; mid_start injects a second start and
  // MTHI/MTLO strobes while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_start,
                        output logic [31:0] gh, output logic [31:0] gl, output logic gdz,
                        output int lat, output bit busy_ok, output bit hold_ok);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    gh = 'x; gl = 'x; gdz = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        if (busy) busy_ok = 1'b0;
        gh = hi; gl = lo; gdz = div_by_zero;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (mid_start && i == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        src_a = 32'd9; src_b = 32'd9; op = 2'b00;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if ({hi, lo, busy, done, div_by_zero} !== 67'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero", hi, lo, busy, done, div_by_zero);
    end
  endtask

  task automatic test_multu_max();
    logic [31:0] gh, gl; logic gdz; int lat; bit bok, hok;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d edges, required 33", lat - 1); end
    checks++;
    if (gh !== 32'hFFFF_FFFE || gl !== 32'h1) begin
      errors++; $display("FAIL multu_max: hi=%h lo=%h required hi=fffffffe lo=00000001", gh, gl);
    end
    checks++;
    if (!bok) begin errors++; $display("FAIL multu_busy: busy=%b, required 1 until done then 0", bok); end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b, required 0", done); end
  endtask

  task automatic test_divu();
    logic [31:0] gh, gl; logic gdz; int lat; bit bok, hok;
    run_op(2'b01, 32'd100, 32'd7, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'd14 || gh !== 32'd2 || gdz !== 1'b0) begin
      errors++; $display("FAIL divu_100_7: lo=%0d hi=%0d dz=%b required lo=14 hi=2 dz=0", gl, gh, gdz);
    end
    run_op(2'b01, 32'd5, 32'd0, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'hFFFF_FFFF || gh !== 32'd5 || gdz !== 1'b1) begin
      errors++; $display("FAIL divu_by_zero: lo=%h hi=%h dz=%b required lo=ffffffff hi=5 dz=1", gl, gh, gdz);
    end
    run_op(2'b00, 32'd2, 32'd3, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'd6 || gh !== 32'd0 || gdz !== 1'b0) begin
      errors++; $display("FAIL dz_clear: lo=%0d hi=%0d dz=%b required lo=6 hi=0 dz=0", gl, gh, gdz);
    end
  endtask

  task automatic test_signed();
    logic [31:0] gh, gl; logic gdz; int lat; bit bok, hok;
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
`ifdef MULDIV_SIGNED_EN
    if (gh !== 32'hFFFF_FFFF || gl !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg3_5: hi=%h lo=%h required hi=ffffffff lo=fffffff1", gh, gl);
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'hFFFF_FFFD || gh !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg7_2: lo=%h hi=%h required lo=fffffffd hi=ffffffff", gl, gh);
    end
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'h8000_0000 || gh !== 32'h0 || gdz !== 1'b0) begin
      errors++; $display("FAIL div_min_m1: lo=%h hi=%h dz=%b required lo=80000000 hi=0 dz=0", gl, gh, gdz);
    end
`else
    if (gh !== 32'h4 || gl !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg3_5: hi=%h lo=%h required hi=00000004 lo=fffffff1", gh, gl);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, b, gh, gl, eh, el; logic [1:0] o; logic gdz, edz; int lat; bit bok, hok;
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(o, a, b, eh, el, edz);
      run_op(o, a, b, 1'b0, gh, gl, gdz, lat, bok, hok);
      checks++;
      if (gh !== eh || gl !== el || gdz !== edz || lat !== 34 || !bok || !hok) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d busy_ok=%b hold_ok=%b required hi=%h lo=%h dz=%b lat=33",
                 o, a, b, gh, gl, gdz, lat - 1, bok, hok, eh, el, edz);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = 2'b00; src_a = 32'd77; src_b = 32'd88;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b required all zero", busy, hi, lo, done);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_no_done: %0d done pulses, required 0", dones); end
  endtask

  task automatic test_start_busy();
    logic [31:0] gh, gl; logic gdz; int lat, dones; bit bok, hok;
    run_op(2'b00, 32'd1000, 32'd1000, 1'b1, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'd1000000 || gh !== 32'd0 || lat !== 34 || !hok) begin
      errors++; $display("FAIL start_busy: lo=%0d hi=%0d lat=%0d hold_ok=%b required lo=1000000 hi=0 lat=33 hold_ok=1",
                         gl, gh, lat - 1, hok);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL start_busy_done_once: %0d extra done pulses, required 0", dones); end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] gh, gl; logic gdz; int lat; bit bok, hok;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h required a5a5a5a5 both", hi, lo);
    end
    hi_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clock); #1;
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h0BAD_F00D || lo !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL mthi_only: hi=%h lo=%h required hi=0badf00d lo=a5a5a5a5", hi, lo);
    end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    run_op(2'b00, 32'd2, 32'd3, 1'b0, gh, gl, gdz, lat, bok, hok);
    checks++;
    if (gl !== 32'd6 || gh !== 32'd0 || !hok) begin
      errors++; $display("FAIL start_beats_write: hi=%h lo=%h hold_ok=%b required hi=0 lo=6 hold_ok=1", gh, gl, hok);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1;
    test_reset();
    test_multu_max();
    test_divu();
    test_signed();
    test_mthi_mtlo();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
